// File: rtl/exe_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : exe_alu_arbiter
// Purpose  : Round-robin share of the execute-stage integer ALU between the
//            issue pipeline (port 0) and the branch/address path (port 1),
//            with a one-deep registered response slot per port.
// Revision : 1.0 - initial release
// ============================================================================
module exe_alu_arbiter #(
    parameter int XLEN  = 64,
    parameter int ALU_W = 10,
    parameter int BJ_W  = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [XLEN-1:0]  req0_op1,
    input  logic [XLEN-1:0]  req0_op2,
    input  logic [ALU_W-1:0] req0_alu_info,
    input  logic             req0_word,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [XLEN-1:0]  req1_op1,
    input  logic [XLEN-1:0]  req1_op2,
    input  logic [ALU_W-1:0] req1_alu_info,
    input  logic             req1_word,
    input  logic [TAG_W-1:0] req1_tag,

    output logic [XLEN-1:0]  alu_op1,
    output logic [XLEN-1:0]  alu_op2,
    output logic [ALU_W-1:0] alu_info,
    output logic             alu_word,
    input  logic [XLEN-1:0]  alu_result,
    input  logic [BJ_W-1:0]  alu_bj,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [XLEN-1:0]  rsp0_data,
    output logic [BJ_W-1:0]  rsp0_bj,
    output logic [TAG_W-1:0] rsp0_tag,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [XLEN-1:0]  rsp1_data,
    output logic [BJ_W-1:0]  rsp1_bj,
    output logic [TAG_W-1:0] rsp1_tag
);

    logic             r_ptr;
    logic             r_rsp0_valid;
    logic [XLEN-1:0]  r_rsp0_data;
    logic [BJ_W-1:0]  r_rsp0_bj;
    logic [TAG_W-1:0] r_rsp0_tag;
    logic             r_rsp1_valid;
    logic [XLEN-1:0]  r_rsp1_data;
    logic [BJ_W-1:0]  r_rsp1_bj;
    logic [TAG_W-1:0] r_rsp1_tag;

    logic w_elig0;
    logic w_elig1;
    logic w_gnt0;
    logic w_gnt1;

    // Holding reset low also suppresses grants so nothing reaches the ALU.
    assign w_elig0 = rst && !flush && req0_valid && (!r_rsp0_valid || rsp0_ready);
    assign w_elig1 = rst && !flush && req1_valid && (!r_rsp1_valid || rsp1_ready);
    assign w_gnt0  = w_elig0 && (!w_elig1 || !r_ptr);
    assign w_gnt1  = w_elig1 && (!w_elig0 ||  r_ptr);

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    always_comb begin
        alu_op1  = '0;
        alu_op2  = '0;
        alu_info = '0;
        alu_word = 1'b0;
        if (w_gnt0) begin
            alu_op1  = req0_op1;
            alu_op2  = req0_op2;
            alu_info = req0_alu_info;
            alu_word = req0_word;
        end else if (w_gnt1) begin
            alu_op1  = req1_op1;
            alu_op2  = req1_op2;
            alu_info = req1_alu_info;
            alu_word = req1_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr        <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp0_data  <= '0;
            r_rsp0_bj    <= '0;
            r_rsp0_tag   <= '0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_data  <= '0;
            r_rsp1_bj    <= '0;
            r_rsp1_tag   <= '0;
        end else begin
            if (w_gnt0)
                r_ptr <= 1'b1;
            else if (w_gnt1)
                r_ptr <= 1'b0;

            // Flush blocks grants, so it only ever empties the slots.
            if (flush) begin
                r_rsp0_valid <= 1'b0;
            end else if (w_gnt0) begin
                r_rsp0_valid <= 1'b1;
                r_rsp0_data  <= alu_result;
                r_rsp0_bj    <= alu_bj;
                r_rsp0_tag   <= req0_tag;
            end else if (rsp0_ready) begin
                r_rsp0_valid <= 1'b0;
            end

            if (flush) begin
                r_rsp1_valid <= 1'b0;
            end else if (w_gnt1) begin
                r_rsp1_valid <= 1'b1;
                r_rsp1_data  <= alu_result;
                r_rsp1_bj    <= alu_bj;
                r_rsp1_tag   <= req1_tag;
            end else if (rsp1_ready) begin
                r_rsp1_valid <= 1'b0;
            end
        end
    end

    assign rsp0_valid = r_rsp0_valid;
    assign rsp0_data  = r_rsp0_data;
    assign rsp0_bj    = r_rsp0_bj;
    assign rsp0_tag   = r_rsp0_tag;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp1_data  = r_rsp1_data;
    assign rsp1_bj    = r_rsp1_bj;
    assign rsp1_tag   = r_rsp1_tag;

endmodule
`default_nettype wire
